// File: rtl/bp_me_uce_mem_responder.sv
// bp_me_uce_mem_responder
//   Memory-side responder for the UCE mem_cmd/mem_resp interface. It accepts one
//   command at a time and services it against a block-granular backing store
//   after latency_p cycles. It then returns exactly one response per command.
//
// Message layout (LSB first), cce_mem_msg_width_lp bits in total:
//   data     [cce_block_width_p]
//   msg_type [4]        0=rd 1=wr 2=uc_rd 3=uc_wr 4=wb, other codes are echoed
//   addr     [paddr_width_p]
//   size     [3]        2^size bytes
//   lce_id   [lce_id_width_p]
//   way_id   [log2(lce_assoc_p)]
//
// Ports:
//   clk_i, reset_i                     clock, asynchronous active-high reset
//   mem_cmd_i / mem_cmd_v_i / mem_cmd_ready_o    command channel (valid/ready)
//   mem_resp_o / mem_resp_v_o / mem_resp_yumi_i  response channel (valid/yumi)
//
// Build option:
//   BP_ME_MEM_STALL_INJECT_EN  when defined, a 16-bit LFSR (seed 16'hACE1)
//   randomly gates command ready and delays the first cycle of response valid.
module bp_me_uce_mem_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int mem_els_p         = 64,
    parameter int latency_p         = 4,
    localparam int way_id_width_lp  = $clog2(lce_assoc_p),
    localparam int cce_mem_msg_width_lp = cce_block_width_p + 4 + paddr_width_p + 3
                                          + lce_id_width_p + way_id_width_lp
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);

    localparam int dataW      = cce_block_width_p;
    localparam int typeLsb    = dataW;
    localparam int addrLsb    = dataW + 4;
    localparam int sizeLsb    = addrLsb + paddr_width_p;
    localparam int blockOffW  = way_id_width_lp + 3;
    localparam int idxW       = $clog2(mem_els_p);
    localparam int blockBytes = cce_block_width_p / 8;
    localparam int cntW       = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

    localparam logic [3:0] MsgRd   = 4'd0;
    localparam logic [3:0] MsgWr   = 4'd1;
    localparam logic [3:0] MsgUcRd = 4'd2;
    localparam logic [3:0] MsgUcWr = 4'd3;
    localparam logic [3:0] MsgWb   = 4'd4;

    typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

    state_e                          state_q, state_d;
    logic [cntW-1:0]                 cnt_q, cnt_d;
    logic [cce_mem_msg_width_lp-1:0] cmd_q;
    logic [dataW-1:0]                resp_data_q;
    logic [dataW-1:0]                mem_q [mem_els_p];

    logic                            cmdXfer;
    logic                            enterResp;
    logic [cce_mem_msg_width_lp-1:0] actCmd;
    logic [3:0]                      actType;
    logic [idxW-1:0]                 actIdx;
    logic [blockOffW-1:0]            actOff;
    logic [2:0]                      actSize;
    logic [dataW-1:0]                actData;
    logic [dataW-1:0]                memBlock;
    logic [dataW-1:0]                writeBlock;
    logic [dataW-1:0]                respData;
    logic [63:0]                     ucDword;
    logic [63:0]                     ucShifted;
    logic                            doWrite;
    int                              ucLo;
    int                              ucHi;
    logic                            unusedActBits;

    assign cmdXfer = mem_cmd_v_i & mem_cmd_ready_o;

    // With latency_p==0 the store is accessed on the accept edge itself, so the
    // command being serviced is still on the input port rather than in cmd_q.
    assign actCmd        = (state_q == e_ready) ? mem_cmd_i : cmd_q;
    assign actType       = actCmd[typeLsb +: 4];
    assign actOff        = actCmd[addrLsb +: blockOffW];
    assign actIdx        = actCmd[addrLsb + blockOffW +: idxW];
    assign actSize       = actCmd[sizeLsb +: 3];
    assign actData       = actCmd[dataW-1:0];
    assign unusedActBits = ^actCmd;

    assign memBlock  = mem_q[actIdx];
    assign ucDword   = memBlock[{actOff[blockOffW-1:3], 6'b000000} +: 64];
    assign ucShifted = ucDword >> {actOff[2:0], 3'b000};

    // Response data and the updated block for the command being completed.
    // Uncached writes are clipped at the end of the block.
    always_comb begin
        writeBlock = memBlock;
        respData   = '0;
        doWrite    = 1'b0;
        ucLo       = int'(actOff);
        ucHi       = ucLo + (1 << actSize);
        case (actType)
            MsgRd, MsgWr: respData = memBlock;
            MsgWb: begin
                writeBlock = actData;
                doWrite    = 1'b1;
            end
            MsgUcRd: respData = dataW'(ucShifted);
            MsgUcWr: begin
                doWrite = 1'b1;
                for (int b = 0; b < blockBytes; b++) begin
                    if ((b >= ucLo) && (b < ucHi)) begin
                        writeBlock[b*8 +: 8] = actData[(b - ucLo)*8 +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef BP_ME_MEM_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        resp_seen_q, resp_seen_d;

    assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign resp_seen_d = mem_resp_v_o & ~mem_resp_yumi_i;

    // Free-running stall pattern; resp_seen_q keeps valid up once shown.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q      <= 16'hACE1;
            resp_seen_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            resp_seen_q <= resp_seen_d;
        end
    end

    assign mem_cmd_ready_o = (state_q == e_ready) & ~reset_i & lfsr_q[0];
    assign mem_resp_v_o    = (state_q == e_resp) & (resp_seen_q | lfsr_q[1]);
`else
    assign mem_cmd_ready_o = (state_q == e_ready) & ~reset_i;
    assign mem_resp_v_o    = (state_q == e_resp);
`endif

    // Next-state logic. enterResp marks the single edge on which the store is
    // read and written for the outstanding command.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enterResp = 1'b0;
        case (state_q)
            e_ready: begin
                if (cmdXfer) begin
                    cnt_d = cntW'(latency_p);
                    if (latency_p == 0) begin
                        state_d   = e_resp;
                        enterResp = 1'b1;
                    end else begin
                        state_d = e_wait;
                    end
                end
            end
            e_wait: begin
                cnt_d = cnt_q - cntW'(1);
                if (cnt_q == cntW'(1)) begin
                    state_d   = e_resp;
                    enterResp = 1'b1;
                end
            end
            e_resp: begin
                if (mem_resp_yumi_i && mem_resp_v_o) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // Control registers; reset drops any latched command.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            cnt_q       <= '0;
            cmd_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cmdXfer) begin
                cmd_q <= mem_cmd_i;
            end
            if (enterResp) begin
                resp_data_q <= respData;
            end
        end
    end

    // Backing store is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (enterResp && doWrite && !reset_i) begin
            mem_q[actIdx] <= writeBlock;
        end
    end

    assign mem_resp_o = {cmd_q[cce_mem_msg_width_lp-1:dataW], resp_data_q};

endmodule

// File: tb/tb_bp_me_uce_mem_responder.sv
`timescale 1ns/1ps
module tb_bp_me_uce_mem_responder;

    localparam int PADDR = 40;
    localparam int BLOCK = 512;
    localparam int LCEID = 4;
    localparam int WAYW  = 3;
    localparam int ELS   = 16;
    localparam int LAT   = 4;
    localparam int MSGW  = BLOCK + 4 + PADDR + 3 + LCEID + WAYW;

    localparam logic [3:0] RD = 4'd0, WR = 4'd1, UCRD = 4'd2, UCWR = 4'd3, WB = 4'd4;

    logic            clk, rst;
    logic [MSGW-1:0] cmd, resp, cmd0, resp0;
    logic            cmdV, cmdReady, respV, yumi;
    logic            cmdV0, cmdReady0, respV0, yumi0;

    int checks = 0;
    int errors = 0;

    // Byte-level reference image of the latency-4 instance's store
    logic [7:0] refMem [ELS][BLOCK/8];

    typedef struct {
        logic [3:0]       msgType;
        logic [PADDR-1:0] addr;
        logic [2:0]       size;
        logic [BLOCK-1:0] data;
        int               hold;
        logic [BLOCK-1:0] expData;
    } vec_t;

    vec_t vecs [13];

    bp_me_uce_mem_responder #(
        .paddr_width_p(PADDR), .cce_block_width_p(BLOCK), .lce_id_width_p(LCEID),
        .lce_assoc_p(8), .mem_els_p(ELS), .latency_p(LAT)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .mem_cmd_i(cmd), .mem_cmd_v_i(cmdV), .mem_cmd_ready_o(cmdReady),
        .mem_resp_o(resp), .mem_resp_v_o(respV), .mem_resp_yumi_i(yumi)
    );

    bp_me_uce_mem_responder #(
        .paddr_width_p(PADDR), .cce_block_width_p(BLOCK), .lce_id_width_p(LCEID),
        .lce_assoc_p(8), .mem_els_p(ELS), .latency_p(0)
    ) dut0 (
        .clk_i(clk), .reset_i(rst),
        .mem_cmd_i(cmd0), .mem_cmd_v_i(cmdV0), .mem_cmd_ready_o(cmdReady0),
        .mem_resp_o(resp0), .mem_resp_v_o(respV0), .mem_resp_yumi_i(yumi0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [MSGW-1:0] packCmd(input logic [3:0] t, input logic [PADDR-1:0] a,
                                                input logic [2:0] s, input logic [LCEID-1:0] l,
                                                input logic [WAYW-1:0] w, input logic [BLOCK-1:0] d);
        return {w, l, s, a, t, d};
    endfunction

    function automatic logic [BLOCK-1:0] rndBlock();
        logic [BLOCK-1:0] r;
        for (int i = 0; i < BLOCK/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference behaviour: byte arithmetic on the image, returns response data
    function automatic logic [BLOCK-1:0] modelExec(input logic [3:0] t, input logic [PADDR-1:0] a,
                                                  input logic [2:0] s, input logic [BLOCK-1:0] d);
        logic [BLOCK-1:0] r;
        int idx, off, base, k;
        r    = '0;
        idx  = int'(a[9:6]);
        off  = int'(a[5:0]);
        base = (off / 8) * 8;
        k    = off % 8;
        case (t)
            RD, WR: for (int b = 0; b < 64; b++) r[b*8 +: 8] = refMem[idx][b];
            WB:     for (int b = 0; b < 64; b++) refMem[idx][b] = d[b*8 +: 8];
            UCRD:   for (int j = 0; j < 8; j++) if (j + k < 8) r[j*8 +: 8] = refMem[idx][base + j + k];
            UCWR:   for (int j = 0; j < (1 << s); j++) if (off + j < 64) refMem[idx][off + j] = d[j*8 +: 8];
            default: ;
        endcase
        return r;
    endfunction

    // One full transaction on the latency-4 instance with timing, data, header and hold checks
    task automatic applyStimulus(input string name, input logic [3:0] t, input logic [PADDR-1:0] a,
                                 input logic [2:0] s, input logic [BLOCK-1:0] d, input int hold,
                                 input logic [BLOCK-1:0] expData);
        logic [MSGW-1:0] m, held;
        int waited;
        m = packCmd(t, a, s, LCEID'($urandom), WAYW'($urandom), d);
        @(negedge clk);
        cmd  = m;
        cmdV = 1'b1;
        waited = 0;
        while (!cmdReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmdReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s accept: ready stayed 0 expected 1", name);
            cmdV = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmdV = 1'b0;
        cmd  = '1;
        waited = 1;
        for (;;) begin
            checkOutput({name, " ready low"}, MSGW'(cmdReady), '0);
            if (respV || waited >= 50) break;
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " latency"}, MSGW'(waited), MSGW'(LAT + 1));
        if (!respV) return;
        checkOutput({name, " data"}, MSGW'(resp[BLOCK-1:0]), MSGW'(expData));
        checkOutput({name, " header"}, MSGW'(resp[MSGW-1:BLOCK]), MSGW'(m[MSGW-1:BLOCK]));
        held = resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({name, " hold resp"}, resp, held);
            checkOutput({name, " hold valid"}, MSGW'(respV), MSGW'(1));
            checkOutput({name, " hold ready"}, MSGW'(cmdReady), '0);
        end
        yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        yumi = 1'b0;
        checkOutput({name, " post valid"}, MSGW'(respV), '0);
        checkOutput({name, " post ready"}, MSGW'(cmdReady), MSGW'(1));
    endtask

    initial begin
        logic [BLOCK-1:0] bPat, b1, b2, b3, rdata, expd;
        logic [3:0]       rt;
        logic [PADDR-1:0] ra;
        logic [2:0]       rs;
        int               respCount;

        for (int i = 0; i < 64; i++) bPat[i*8 +: 8] = 8'(i * 7 + 3);
        b1 = bPat; b1[127:64]  = 64'h1122334455667788;
        b2 = b1;   b2[511:480] = 32'hEEFF0011;
        b3 = b2;   b3[23:8]    = 16'hBEEF;

        vecs[0]  = '{WB,   40'h80,    3'd6, bPat,       0,  '0};
        vecs[1]  = '{RD,   40'h80,    3'd6, '0,         10, bPat};
        vecs[2]  = '{UCWR, 40'h88,    3'd3, BLOCK'(64'h1122334455667788), 0, '0};
        vecs[3]  = '{UCRD, 40'h88,    3'd3, '0,         0,  BLOCK'(64'h1122334455667788)};
        vecs[4]  = '{RD,   40'h80,    3'd6, '0,         0,  b1};
        vecs[5]  = '{UCRD, 40'h8B,    3'd0, '0,         0,  BLOCK'(64'h0000001122334455)};
        vecs[6]  = '{4'hF, 40'h80,    3'd6, rndBlock(), 1,  '0};
        vecs[7]  = '{UCWR, 40'hBC,    3'd3, BLOCK'(64'hAABBCCDDEEFF0011), 0, '0};
        vecs[8]  = '{WR,   40'h480,   3'd6, '0,         0,  b2};
        vecs[9]  = '{UCWR, 40'h81,    3'd1, BLOCK'(16'hBEEF), 0, '0};
        vecs[10] = '{WB,   40'hC0,    3'd6, ~bPat,      0,  '0};
        vecs[11] = '{RD,   40'h80,    3'd6, '0,         2,  b3};
        vecs[12] = '{RD,   40'h100C0, 3'd6, '0,         0,  ~bPat};

        rst = 1'b1; cmd = '0; cmdV = 1'b0; yumi = 1'b0;
        cmd0 = '0; cmdV0 = 1'b0; yumi0 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset valid", MSGW'(respV), '0);
        checkOutput("reset ready", MSGW'(cmdReady), '0);
        checkOutput("reset resp", resp, '0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle ready", MSGW'(cmdReady), MSGW'(1));
        checkOutput("idle valid", MSGW'(respV), '0);

        for (int i = 0; i < 13; i++) begin
            expd = modelExec(vecs[i].msgType, vecs[i].addr, vecs[i].size, vecs[i].data);
            applyStimulus($sformatf("vec%0d", i), vecs[i].msgType, vecs[i].addr, vecs[i].size,
                          vecs[i].data, vecs[i].hold, vecs[i].expData);
        end

        // Reset while a writeback is waiting: no response, block untouched
        @(negedge clk);
        checkOutput("abort ready", MSGW'(cmdReady), MSGW'(1));
        cmd  = packCmd(WB, 40'h80, 3'd6, '0, '0, {16{32'h0BADF00D}});
        cmdV = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmdV = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort valid", MSGW'(respV), '0);
        checkOutput("abort ready in reset", MSGW'(cmdReady), '0);
        checkOutput("abort resp", resp, '0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("abort reread", RD, 40'h80, 3'd6, '0, 0, b3);

        // Randomized traffic against the reference image
        for (int blk = 0; blk < ELS; blk++) begin
            ra = {PADDR'($urandom_range(0, 255)) << 10} | PADDR'(blk << 6);
            rdata = rndBlock();
            expd = modelExec(WB, ra, 3'd6, rdata);
            applyStimulus($sformatf("init%0d", blk), WB, ra, 3'd6, rdata, 0, expd);
        end
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: rt = RD;
                1: rt = WR;
                2: rt = WB;
                3: rt = UCRD;
                default: rt = UCWR;
            endcase
            ra    = {8'($urandom), $urandom};
            rs    = 3'($urandom_range(0, 6));
            rdata = rndBlock();
            expd  = modelExec(rt, ra, rs, rdata);
            applyStimulus($sformatf("rnd%0d", n), rt, ra, rs, rdata, $urandom_range(0, 3), expd);
        end

        // Zero-latency instance: streamed commands with immediate yumi
        @(negedge clk);
        checkOutput("lat0 ready", MSGW'(cmdReady0), MSGW'(1));
        cmd0  = packCmd(WB, 40'h80, 3'd6, '0, '0, bPat);
        cmdV0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd0 = packCmd(RD, 40'h80, 3'd6, 4'h5, 3'h2, '0);
        respCount = 0;
        for (int k = 1; k <= 12; k++) begin
            checkOutput($sformatf("lat0 valid k%0d", k), MSGW'(respV0), MSGW'(k % 2));
            if (respV0 && k > 1) checkOutput($sformatf("lat0 data k%0d", k), MSGW'(resp0[BLOCK-1:0]), MSGW'(bPat));
            if (respV0) respCount++;
            yumi0 = respV0;
            @(negedge clk);
        end
        cmdV0 = 1'b0;
        yumi0 = 1'b0;
        checkOutput("lat0 resp count", MSGW'(respCount), MSGW'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
